mmio_uart_hub: RTL and testbench
================================

# mmio_uart_hub

Parametrised memory-mapped I/O hub between the CPU memory stage and the physical RAM controller. It decodes a window of NCHAN serial channels at BASE_ADDR and gives each channel an RX FIFO, a TX holding register with valid/ready handshake, and sticky error flags. All other addresses pass through to RAM unchanged. It generalises the fixed two-port, unbuffered 0xBF00–0xBF03 decode to N buffered channels.

## Interface
- NCHAN, 2, number of serial channels (1..8)
- FIFO_DEPTH, 8, RX FIFO entries per channel (power of 2, 2..16)
- BASE_ADDR, 16'hBF00, first MMIO address (even)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- mem_rw  in  2  2'b01 read, 2'b10 write, others idle
- cpu_addr  in  16  virtual address from memory stage
- cpu_wdata  in  16  write data (low byte used by MMIO)
- cpu_rdata  out  16  read data to memory stage
- ram_addr  out  16  address to RAM controller
- ram_rdata  in  16  RAM read data
- ram_we  out  1  RAM write strobe
- rx_data  in  NCHAN*8  received bytes, channel k at [8k+7:8k]
- rx_valid  in  NCHAN  one-cycle strobe per received byte
- tx_data  out  NCHAN*8  byte offered to transmitter k
- tx_valid  out  NCHAN  TX holding register k full
- tx_ready  in  NCHAN  transmitter k accepts byte when high with tx_valid

## Operation
- Address map: BASE_ADDR+2k = DATA(k), BASE_ADDR+2k+1 = STATUS(k), k<NCHAN. Every other address, including unused slots in the BF page, is RAM.
- RAM path: ram_addr = cpu_addr always; cpu_rdata = ram_rdata; ram_we = (mem_rw==2'b10) only for non-MMIO addresses.
- STATUS(k) read: bit0 TX holding empty; bit1 RX FIFO non-empty; bit2 RX overrun sticky; bit3 TX drop sticky; bits[7:4] 0; bits[15:8] RX count. Reading clears bits 2 and 3 at the clock edge. Writes to STATUS are ignored.
- DATA(k) read:
  - Non-empty FIFO: cpu_rdata = {8'h00, head}, and the edge pops one entry.
  - Empty FIFO: returns 16'h0000, no pop, no flag.
- DATA(k) write:
  - Accepted if the holding register is empty, or if tx_valid&tx_ready completes on the same edge. The low byte is latched and tx_valid is 1 next cycle.
  - Otherwise the write is dropped and the TX drop flag is set.
- TX handshake: tx_valid and tx_data stay stable until an edge with tx_ready=1. tx_valid then clears unless a new write was accepted on that edge.
- RX push on rx_valid[k]:
  - Not full: the byte is written at the tail.
  - Full with a pop on the same edge: the push is accepted and the count is unchanged.
  - Full without a pop: the byte is discarded and overrun is set.
- Simultaneous push and pop on a non-empty FIFO: count unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH.
- Channels are independent. Only the addressed channel is affected by CPU access. All channels accept rx_valid and tx_ready every cycle.

## Timing
- Read path (RAM, DATA, STATUS) is combinational from cpu_addr/mem_rw in the same cycle.
- Pops, pushes, flag clears, and TX latches take effect at the rising clk edge. Status reflects them from the next cycle.
- One pop per cycle while mem_rw=2'b01 addresses DATA(k). The memory stage holds a read for exactly one cycle.
- RX byte to CPU-visible: 1 cycle after the rx_valid edge.
- CPU write to tx_valid high: 1 cycle.
- Reset asserted (rst=0), asynchronously, including mid-transfer:
  - All FIFOs empty, pointers and counts 0.
  - Overrun and drop flags 0; tx_valid all 0; tx_data all 0.
  - Pending bytes are lost.
- cpu_rdata, ram_addr and ram_we are combinational and follow their inputs during reset. ram_we is still gated by the decode.

## Test plan
- Pass-through: write 16'h1234 to 0x0100, then read it. Expect ram_we=1 and ram_addr=0x0100 on the write. No MMIO state change.
- RX fill/overrun (DEPTH=8, ch0):
  - Pulse rx_valid 9 times with bytes 0x01..0x09.
  - STATUS(0) reads 16'h0806 (count 8, non-empty, overrun). The next STATUS read shows bit2=0.
  - 8 DATA reads return 0x0001..0x0008. A 9th read returns 0x0000.
- Push/pop collision on full FIFO:
  - rx_valid with 0xAA on the same cycle as a DATA read.
  - The read returns the head and the count stays 8. 0xAA is last out after wrap-around.
- TX handshake (ch1):
  - Write 0x0041 to BASE+2 with tx_ready=0. tx_valid[1]=1 and tx_data=0x41 next cycle.
  - A second write, 0x42, is dropped and STATUS(1) bit3=1.
  - Raise tx_ready: tx_valid clears. A write in the same cycle as tx_ready is accepted.
- Channel isolation (NCHAN=4): traffic on ch2 leaves ch0/1/3 status unchanged. Address BASE+8 routes to RAM.
- Reset mid-operation: with 3 RX bytes queued and tx_valid high, pulse rst=0 asynchronously. All STATUS read 16'h0001 and tx_valid=0 immediately.

Source files
------------

// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: decodes NCHAN serial channels at BASE_ADDR (DATA at even,
// STATUS at odd offsets) and passes every other access through to RAM.
// Each channel owns an RX FIFO, a TX holding register and sticky error flags.

// One serial channel: RX FIFO, TX holding register, overrun/drop flags.
module mmio_uart_chan #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_data,
    input  logic        rd_stat,
    input  logic        wr_data,
    input  logic [7:0]  wdata,
    input  logic [7:0]  rx_byte,
    input  logic        rx_vld,
    input  logic        tx_rdy,
    output logic [7:0]  tx_byte,
    output logic        tx_vld,
    output logic [15:0] data_val,
    output logic [15:0] stat_val
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  ovr, drop;
    logic                  empty, full, pop, push, wr_ok;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign pop   = rd_data & ~empty;
    // A full FIFO still takes a byte when the same edge frees a slot.
    assign push  = rx_vld & (~full | pop);
    // The holding register is free if empty or being drained this edge.
    assign wr_ok = wr_data & (~tx_vld | tx_rdy);

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_byte;
    end

    // Sticky flags; a new event on the clearing edge wins so it is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr  <= 1'b0;
            drop <= 1'b0;
        end else begin
            if (rx_vld & full & ~pop)  ovr <= 1'b1;
            else if (rd_stat)          ovr <= 1'b0;
            if (wr_data & ~wr_ok)      drop <= 1'b1;
            else if (rd_stat)          drop <= 1'b0;
        end
    end

    // TX holding register with valid/ready handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_byte <= '0;
            tx_vld  <= 1'b0;
        end else if (wr_ok) begin
            tx_byte <= wdata;
            tx_vld  <= 1'b1;
        end else if (tx_rdy) begin
            tx_vld  <= 1'b0;
        end
    end

    // CPU-visible DATA and STATUS words.
    always_comb begin
        data_val = empty ? 16'h0000 : {8'h00, mem[rd_ptr]};
        stat_val = {8'(count), 4'b0000, drop, ovr, ~empty, ~tx_vld};
    end
endmodule

// Address decode, RAM pass-through and channel array.
module mmio_uart_hub #(
    parameter int          NCHAN      = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BASE_ADDR  = 16'hBF00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mem_rw,
    input  logic [15:0]          cpu_addr,
    input  logic [15:0]          cpu_wdata,
    output logic [15:0]          cpu_rdata,
    output logic [15:0]          ram_addr,
    input  logic [15:0]          ram_rdata,
    output logic                 ram_we,
    input  logic [NCHAN*8-1:0]   rx_data,
    input  logic [NCHAN-1:0]     rx_valid,
    output logic [NCHAN*8-1:0]   tx_data,
    output logic [NCHAN-1:0]     tx_valid,
    input  logic [NCHAN-1:0]     tx_ready
);
    localparam logic [15:0] SPAN = 16'(2 * NCHAN);

    logic [15:0]                 off;
    logic                        hit, is_rd, is_wr;
    logic [NCHAN-1:0]            sel;
    logic [NCHAN-1:0][15:0]      data_v, stat_v;
    logic                        unused_hi;

    // Offsets below BASE_ADDR wrap to large values and fall outside SPAN.
    assign off       = cpu_addr - BASE_ADDR;
    assign hit       = (off < SPAN);
    assign is_rd     = (mem_rw == 2'b01);
    assign is_wr     = (mem_rw == 2'b10);
    assign ram_addr  = cpu_addr;
    assign ram_we    = is_wr & ~hit;
    assign unused_hi = ^cpu_wdata[15:8];

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        assign sel[k] = hit && (off[15:1] == 15'(k));

        mmio_uart_chan #(.DEPTH(FIFO_DEPTH)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .rd_data  (sel[k] & is_rd & ~off[0]),
            .rd_stat  (sel[k] & is_rd &  off[0]),
            .wr_data  (sel[k] & is_wr & ~off[0]),
            .wdata    (cpu_wdata[7:0]),
            .rx_byte  (rx_data[8*k +: 8]),
            .rx_vld   (rx_valid[k]),
            .tx_rdy   (tx_ready[k]),
            .tx_byte  (tx_data[8*k +: 8]),
            .tx_vld   (tx_valid[k]),
            .data_val (data_v[k]),
            .stat_val (stat_v[k])
        );
    end

    // Read mux: RAM unless a channel slot is addressed.
    always_comb begin
        cpu_rdata = ram_rdata;
        for (int k = 0; k < NCHAN; k++) begin
            if (sel[k]) cpu_rdata = off[0] ? stat_v[k] : data_v[k];
        end
    end
endmodule

// File: tb/tb_mmio_uart_hub.sv
// Directed bench for mmio_uart_hub (NCHAN=4, FIFO_DEPTH=8, BASE=0xBF00).
module tb_mmio_uart_hub;
    localparam int          NCHAN = 4;
    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'hBF00;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           mem_rw;
    logic [15:0]          cpu_addr, cpu_wdata, cpu_rdata, ram_addr, ram_rdata;
    logic                 ram_we;
    logic [NCHAN*8-1:0]   rx_data, tx_data;
    logic [NCHAN-1:0]     rx_valid, tx_valid, tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    mmio_uart_hub #(.NCHAN(NCHAN), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .mem_rw(mem_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr),
        .ram_rdata(ram_rdata), .ram_we(ram_we), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] stat(input int k);
        return BASE + 16'(2 * k + 1);
    endfunction

    task automatic rd_chk(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        mem_rw   = 2'b01;
        cpu_addr = addr;
        #1;
        chk(tag, cpu_rdata, exp);
        tick();
        mem_rw = 2'b00;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        mem_rw    = 2'b10;
        cpu_addr  = addr;
        cpu_wdata = data;
        tick();
        mem_rw = 2'b00;
    endtask

    task automatic rx_push(input int ch, input logic [7:0] b);
        rx_data[ch*8 +: 8] = b;
        rx_valid[ch]       = 1'b1;
        tick();
        rx_valid = '0;
    endtask

    initial begin
        rst = 1'b0; mem_rw = 2'b00; cpu_addr = '0; cpu_wdata = '0;
        ram_rdata = '0; rx_data = '0; rx_valid = '0; tx_ready = '0;

        // Reset state, and decode still gating ram_we while in reset.
        #2;
        chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
        chk("rst_tx_data", tx_data[15:0], 16'h0000);
        mem_rw = 2'b01; cpu_addr = stat(0); #1;
        chk("rst_stat0", cpu_rdata, 16'h0001);
        mem_rw = 2'b10; cpu_addr = BASE; #1;
        chk("rst_we_mmio", 16'(ram_we), 16'h0000);
        cpu_addr = 16'h0100; #1;
        chk("rst_we_ram", 16'(ram_we), 16'h0001);
        mem_rw = 2'b00;
        tick();
        rst = 1'b1;
        tick();

        // RAM pass-through.
        mem_rw = 2'b10; cpu_addr = 16'h0100; cpu_wdata = 16'h1234; #1;
        chk("pt_we", 16'(ram_we), 16'h0001);
        chk("pt_addr", ram_addr, 16'h0100);
        tick();
        mem_rw = 2'b01; ram_rdata = 16'h1234; #1;
        chk("pt_rdata", cpu_rdata, 16'h1234);
        tick();
        mem_rw = 2'b00;
        chk("pt_tx_valid", 16'(tx_valid), 16'h0000);
        rd_chk(stat(0), 16'h0001, "pt_stat0");

        // Fill ch0 TX holding so its STATUS bit0 reads 0 during the RX test.
        mem_rw = 2'b10; cpu_addr = BASE; cpu_wdata = 16'h0055; #1;
        chk("tx0_we_gated", 16'(ram_we), 16'h0000);
        tick();
        mem_rw = 2'b00;
        chk("tx0_valid", 16'(tx_valid[0]), 16'h0001);
        chk("tx0_data", 16'(tx_data[7:0]), 16'h0055);

        // RX fill and overrun on ch0.
        for (int i = 1; i <= 9; i++) rx_push(0, 8'(i));
        rd_chk(stat(0), 16'h0806, "fill_stat");
        rd_chk(stat(0), 16'h0802, "fill_stat_clr");
        for (int i = 1; i <= 8; i++) rd_chk(BASE, 16'(i), "fill_pop");
        rd_chk(BASE, 16'h0000, "fill_pop_empty");
        rd_chk(stat(0), 16'h0000, "fill_stat_empty");

        // Drain ch0 TX holding.
        tx_ready[0] = 1'b1;
        chk("tx0_pre_ready", 16'(tx_valid[0]), 16'h0001);
        tick();
        tx_ready[0] = 1'b0;
        chk("tx0_drained", 16'(tx_valid[0]), 16'h0000);
        rd_chk(stat(0), 16'h0001, "tx0_stat");

        // Push/pop collision on a full FIFO; pointers wrap.
        for (int i = 0; i < 8; i++) rx_push(0, 8'h11 + 8'(i));
        rd_chk(stat(0), 16'h0803, "col_full");
        rx_data[7:0] = 8'hAA; rx_valid[0] = 1'b1;
        mem_rw = 2'b01; cpu_addr = BASE; #1;
        chk("col_head", cpu_rdata, 16'h0011);
        tick();
        rx_valid = '0; mem_rw = 2'b00;
        rd_chk(stat(0), 16'h0803, "col_count");
        for (int i = 0; i < 7; i++) rd_chk(BASE, 16'h0012 + 16'(i), "col_pop");
        rd_chk(BASE, 16'h00AA, "col_last");
        rd_chk(BASE, 16'h0000, "col_empty");
        rd_chk(stat(0), 16'h0001, "col_stat");

        // TX handshake on ch1.
        wr(BASE + 16'd2, 16'h0041);
        chk("tx1_valid", 16'(tx_valid[1]), 16'h0001);
        chk("tx1_data", 16'(tx_data[15:8]), 16'h0041);
        wr(BASE + 16'd2, 16'h0042);
        chk("tx1_hold", 16'(tx_data[15:8]), 16'h0041);
        rd_chk(stat(1), 16'h0008, "tx1_drop");
        rd_chk(stat(1), 16'h0000, "tx1_drop_clr");
        tx_ready[1] = 1'b1;
        mem_rw = 2'b10; cpu_addr = BASE + 16'd2; cpu_wdata = 16'h0043; #1;
        chk("tx1_pre", 16'(tx_valid[1]), 16'h0001);
        tick();
        mem_rw = 2'b00;
        chk("tx1_new_valid", 16'(tx_valid[1]), 16'h0001);
        chk("tx1_new_data", 16'(tx_data[15:8]), 16'h0043);
        tick();
        tx_ready[1] = 1'b0;
        chk("tx1_clear", 16'(tx_valid[1]), 16'h0000);
        wr(stat(1), 16'h00FF);
        rd_chk(stat(1), 16'h0001, "tx1_stat_wr_ignored");

        // Channel isolation: traffic on ch2 only.
        rx_push(2, 8'h21);
        rx_push(2, 8'h22);
        wr(BASE + 16'd4, 16'h0077);
        wr(BASE + 16'd4, 16'h0078);
        rd_chk(stat(2), 16'h020A, "iso_stat2");
        rd_chk(stat(0), 16'h0001, "iso_stat0");
        rd_chk(stat(1), 16'h0001, "iso_stat1");
        rd_chk(stat(3), 16'h0001, "iso_stat3");
        chk("iso_tx_valid", 16'(tx_valid), 16'h0004);
        chk("iso_tx_data", 16'(tx_data[23:16]), 16'h0077);
        ram_rdata = 16'hBEEF;
        rd_chk(BASE + 16'd8, 16'hBEEF, "iso_ram_rd8");
        rd_chk(BASE + 16'd9, 16'hBEEF, "iso_ram_rd9");
        mem_rw = 2'b10; cpu_addr = BASE + 16'd8; #1;
        chk("iso_ram_we8", 16'(ram_we), 16'h0001);
        tick();
        mem_rw = 2'b00;

        // Asynchronous reset mid-operation.
        rx_push(2, 8'h23);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_tx_valid", 16'(tx_valid), 16'h0000);
        chk("ar_tx_data_lo", tx_data[15:0], 16'h0000);
        chk("ar_tx_data_hi", tx_data[31:16], 16'h0000);
        mem_rw = 2'b01;
        for (int k = 0; k < NCHAN; k++) begin
            cpu_addr = stat(k); #1;
            chk("ar_stat", cpu_rdata, 16'h0001);
        end
        mem_rw = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rd_chk(BASE + 16'd4, 16'h0000, "ar_data2");
        rd_chk(stat(2), 16'h0001, "ar_stat2_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
